// File: rtl/mult_div_unit_if.sv
// Handshake and result bus between the multicycle control unit and the
// MULT/DIV datapath: one-cycle start with operands, busy/done status and
// the HI/LO register pair.
interface mult_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, op, a_in, b_in,
    input  busy, done, div_zero, hi_out, lo_out
  );

  modport slave (
    input  start, op, a_in, b_in,
    output busy, done, div_zero, hi_out, lo_out
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT/DIV unit producing the HI/LO pair.
// MULT: radix-2 Booth over a 2*WIDTH+1 product register.
// DIV : restoring unsigned division on magnitudes, signs fixed up on the
//       final iteration. Divide by zero finishes immediately with div_zero.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic           clock,
  input logic           reset,
  mult_div_unit_if.slave bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]   count;
  logic               op_r;
  logic               q_neg;
  logic               r_neg;
  logic               dz_r;
  logic [WIDTH-1:0]   m_r;
  logic [2*WIDTH:0]   p_r;
  logic [2*WIDTH:0]   p_nxt;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic               b_zero;
  logic [WIDTH:0]     booth_hi;
  logic [WIDTH:0]     m_ext;
  logic [WIDTH:0]     booth_sum;
  logic [WIDTH-1:0]   div_shift;
  logic [WIDTH:0]     div_diff;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  // Operand magnitudes for division (MIN_INT maps to unsigned 2^(WIDTH-1))
  always_comb begin
    a_abs  = bus.a_in[WIDTH-1] ? -bus.a_in : bus.a_in;
    b_abs  = bus.b_in[WIDTH-1] ? -bus.b_in : bus.b_in;
    b_zero = (bus.b_in == ZERO);
  end

  // One Booth or restoring-division step plus the final signed result
  always_comb begin
    // Booth add/sub is done one bit wider so a MIN_INT multiplicand cannot
    // overflow; the arithmetic shift then drops back to WIDTH bits of HI.
    booth_hi  = {p_r[2*WIDTH], p_r[2*WIDTH:WIDTH+1]};
    m_ext     = {m_r[WIDTH-1], m_r};
    booth_sum = booth_hi;
    case (p_r[1:0])
      2'b01:   booth_sum = booth_hi + m_ext;
      2'b10:   booth_sum = booth_hi - m_ext;
      default: booth_sum = booth_hi;
    endcase

    // Partial remainder is always below the divisor, so its top bit is zero
    // and the shifted value fits in WIDTH bits.
    div_shift = {p_r[2*WIDTH-2:WIDTH], p_r[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {1'b0, m_r};

    if (op_r) begin
      p_nxt = {1'b0,
               div_diff[WIDTH] ? div_shift : div_diff[WIDTH-1:0],
               p_r[WIDTH-2:0], ~div_diff[WIDTH]};
    end else begin
      p_nxt = {booth_sum, p_r[WIDTH:1]};
    end

    quo = p_nxt[WIDTH-1:0];
    rem = p_nxt[2*WIDTH-1:WIDTH];
    if (op_r) begin
      res_lo = q_neg ? -quo : quo;
      res_hi = r_neg ? -rem : rem;
    end else begin
      res_lo = p_nxt[WIDTH:1];
      res_hi = p_nxt[2*WIDTH:WIDTH+1];
    end
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = (bus.op && b_zero) ? FINISH : RUN;
      end
      RUN: begin
        if (count == LAST) state_nxt = FINISH;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    bus.busy     = (state == RUN);
    bus.done     = (state == FINISH);
    bus.div_zero = (state == FINISH) && dz_r;
  end

  // Operand capture, iteration and HI/LO write-back
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
      op_r  <= 1'b0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      dz_r  <= 1'b0;
      m_r   <= '0;
      p_r   <= '0;
      hi_r  <= '0;
      lo_r  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_r  <= bus.op;
            q_neg <= bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1];
            r_neg <= bus.a_in[WIDTH-1];
            dz_r  <= bus.op & b_zero;
            count <= '0;
            if (bus.op) begin
              m_r <= b_abs;
              p_r <= {1'b0, ZERO, a_abs};
            end else begin
              m_r <= bus.a_in;
              p_r <= {ZERO, bus.b_in, 1'b0};
            end
          end
        end
        RUN: begin
          p_r   <= p_nxt;
          count <= count + 1'b1;
          if (count == LAST) begin
            hi_r <= res_hi;
            lo_r <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hi_out = hi_r;
  assign bus.lo_out = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit: reset, MULT/DIV results, latency,
// divide by zero, reset abort and start-handling corner cases.
module tb_mult_div_unit;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Issue one operation and follow it to done (bounded), then back to IDLE.
  // edges counts the start edge as 1; busy_cnt counts sampled busy cycles.
  task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                        output int edges, output int busy_cnt, output int dz_cnt,
                        output bit got_done);
    bus.op    = op;
    bus.a_in  = a;
    bus.b_in  = b;
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    edges    = 1;
    busy_cnt = 0;
    dz_cnt   = 0;
    got_done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.div_zero) dz_cnt++;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        got_done = 1'b1;
        break;
      end
      @(posedge clock); #1;
      edges++;
    end
    if (got_done) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_cmp++; if (bus.div_zero !== 1'b0) begin n_err++; $display("FAIL reset_div_zero: got %b expected 0", bus.div_zero); end
    n_cmp++; if (bus.hi_out !== 32'h0) begin n_err++; $display("FAIL reset_hi: got %h expected 00000000", bus.hi_out); end
    n_cmp++; if (bus.lo_out !== 32'h0) begin n_err++; $display("FAIL reset_lo: got %h expected 00000000", bus.lo_out); end
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL post_reset_idle_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_mult();
    int edges, busy_cnt, dz_cnt;
    bit got_done;
    run_op(OP_MULT, 32'd7, 32'hFFFF_FFFD, edges, busy_cnt, dz_cnt, got_done);
    n_cmp++; if (got_done !== 1'b1) begin n_err++; $display("FAIL mult_done_seen: got %b expected 1", got_done); end
    n_cmp++; if (edges != 33) begin n_err++; $display("FAIL mult_latency: got %0d edges expected 33", edges); end
    n_cmp++; if (busy_cnt != 32) begin n_err++; $display("FAIL mult_busy_cycles: got %0d expected 32", busy_cnt); end
    n_cmp++; if (dz_cnt != 0) begin n_err++; $display("FAIL mult_div_zero: got %0d pulses expected 0", dz_cnt); end
    n_cmp++; if (bus.hi_out !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_7x-3_hi: got %h expected ffffffff", bus.hi_out); end
    n_cmp++; if (bus.lo_out !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mult_7x-3_lo: got %h expected ffffffeb", bus.lo_out); end
  endtask

  task automatic test_reset_mid_run();
    int done_cnt, busy_cnt;
    bus.op    = OP_MULT;
    bus.a_in  = 32'd5;
    bus.b_in  = 32'd7;
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (9) begin @(posedge clock); #1; end
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL abort_done: got %b expected 0", bus.done); end
    n_cmp++; if (bus.hi_out !== 32'h0) begin n_err++; $display("FAIL abort_hi: got %h expected 00000000", bus.hi_out); end
    n_cmp++; if (bus.lo_out !== 32'h0) begin n_err++; $display("FAIL abort_lo: got %h expected 00000000", bus.lo_out); end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    done_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clock); #1;
      if (bus.done) done_cnt++;
      if (bus.busy) busy_cnt++;
    end
    n_cmp++; if (done_cnt != 0) begin n_err++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_cnt); end
    n_cmp++; if (busy_cnt != 0) begin n_err++; $display("FAIL abort_no_busy: got %0d cycles expected 0", busy_cnt); end
  endtask

  task automatic test_mult_corners();
    int edges, busy_cnt, dz_cnt;
    bit got_done;
    run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, edges, busy_cnt, dz_cnt, got_done);
    n_cmp++; if (got_done !== 1'b1) begin n_err++; $display("FAIL mult_min_done: got %b expected 1", got_done); end
    n_cmp++; if (bus.hi_out !== 32'h4000_0000) begin n_err++; $display("FAIL mult_minxmin_hi: got %h expected 40000000", bus.hi_out); end
    n_cmp++; if (bus.lo_out !== 32'h0) begin n_err++; $display("FAIL mult_minxmin_lo: got %h expected 00000000", bus.lo_out); end
    run_op(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, edges, busy_cnt, dz_cnt, got_done);
    n_cmp++; if (bus.hi_out !== 32'h0) begin n_err++; $display("FAIL mult_m1xm1_hi: got %h expected 00000000", bus.hi_out); end
    n_cmp++; if (bus.lo_out !== 32'h1) begin n_err++; $display("FAIL mult_m1xm1_lo: got %h expected 00000001", bus.lo_out); end
    run_op(OP_MULT, 32'h0001_0000, 32'h0003_0005, edges, busy_cnt, dz_cnt, got_done);
    n_cmp++; if (bus.hi_out !== 32'h0000_0003) begin n_err++; $display("FAIL mult_wide_hi: got %h expected 00000003", bus.hi_out); end
    n_cmp++; if (bus.lo_out !== 32'h0005_0000) begin n_err++; $display("FAIL mult_wide_lo: got %h expected 00050000", bus.lo_out); end
  endtask

  task automatic test_div();
    int edges, busy_cnt, dz_cnt;
    bit got_done;
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, edges, busy_cnt, dz_cnt, got_done);
    n_cmp++; if (edges != 33) begin n_err++; $display("FAIL div_latency: got %0d edges expected 33", edges); end
    n_cmp++; if (busy_cnt != 32) begin n_err++; $display("FAIL div_busy_cycles: got %0d expected 32", busy_cnt); end
    n_cmp++; if (bus.lo_out !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_-7/2_lo: got %h expected fffffffd", bus.lo_out); end
    n_cmp++; if (bus.hi_out !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_-7/2_hi: got %h expected ffffffff", bus.hi_out); end
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, edges, busy_cnt, dz_cnt, got_done);
    n_cmp++; if (bus.lo_out !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_7/-2_lo: got %h expected fffffffd", bus.lo_out); end
    n_cmp++; if (bus.hi_out !== 32'h1) begin n_err++; $display("FAIL div_7/-2_hi: got %h expected 00000001", bus.hi_out); end
    run_op(OP_DIV, 32'd100, 32'd7, edges, busy_cnt, dz_cnt, got_done);
    n_cmp++; if (bus.lo_out !== 32'd14) begin n_err++; $display("FAIL div_100/7_lo: got %h expected 0000000e", bus.lo_out); end
    n_cmp++; if (bus.hi_out !== 32'd2) begin n_err++; $display("FAIL div_100/7_hi: got %h expected 00000002", bus.hi_out); end
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, edges, busy_cnt, dz_cnt, got_done);
    n_cmp++; if (dz_cnt != 0) begin n_err++; $display("FAIL div_ovf_div_zero: got %0d pulses expected 0", dz_cnt); end
    n_cmp++; if (bus.lo_out !== 32'h8000_0000) begin n_err++; $display("FAIL div_ovf_lo: got %h expected 80000000", bus.lo_out); end
    n_cmp++; if (bus.hi_out !== 32'h0) begin n_err++; $display("FAIL div_ovf_hi: got %h expected 00000000", bus.hi_out); end
  endtask

  task automatic test_div_zero();
    int edges, busy_cnt, dz_cnt;
    bit got_done;
    // 0x451 / 0x20 leaves quotient 0x22 and remainder 0x11 in LO/HI
    run_op(OP_DIV, 32'h0000_0451, 32'h0000_0020, edges, busy_cnt, dz_cnt, got_done);
    n_cmp++; if (bus.hi_out !== 32'h11) begin n_err++; $display("FAIL dz_setup_hi: got %h expected 00000011", bus.hi_out); end
    n_cmp++; if (bus.lo_out !== 32'h22) begin n_err++; $display("FAIL dz_setup_lo: got %h expected 00000022", bus.lo_out); end
    run_op(OP_DIV, 32'd100, 32'd0, edges, busy_cnt, dz_cnt, got_done);
    n_cmp++; if (got_done !== 1'b1) begin n_err++; $display("FAIL dz_done_seen: got %b expected 1", got_done); end
    n_cmp++; if (edges != 1) begin n_err++; $display("FAIL dz_latency: got %0d edges expected 1", edges); end
    n_cmp++; if (dz_cnt != 1) begin n_err++; $display("FAIL dz_pulse: got %0d pulses expected 1", dz_cnt); end
    n_cmp++; if (busy_cnt != 0) begin n_err++; $display("FAIL dz_busy: got %0d cycles expected 0", busy_cnt); end
    n_cmp++; if (bus.hi_out !== 32'h11) begin n_err++; $display("FAIL dz_hi_kept: got %h expected 00000011", bus.hi_out); end
    n_cmp++; if (bus.lo_out !== 32'h22) begin n_err++; $display("FAIL dz_lo_kept: got %h expected 00000022", bus.lo_out); end
  endtask

  task automatic test_start_held();
    int edges, busy_cnt, dz_cnt, done_cnt;
    bit got_done;
    bus.op    = OP_MULT;
    bus.a_in  = 32'd5;
    bus.b_in  = 32'd6;
    bus.start = 1'b1;
    @(posedge clock); #1;
    // Operands change after capture; start stays high throughout
    bus.a_in = 32'd9;
    bus.b_in = 32'd9;
    done_cnt = 0;
    edges    = 1;
    for (int i = 0; i < 100; i++) begin
      if (bus.done) begin
        done_cnt++;
        break;
      end
      @(posedge clock); #1;
      edges++;
    end
    n_cmp++; if (done_cnt != 1) begin n_err++; $display("FAIL held_done_seen: got %0d expected 1", done_cnt); end
    n_cmp++; if (edges != 33) begin n_err++; $display("FAIL held_latency: got %0d edges expected 33", edges); end
    n_cmp++; if (bus.lo_out !== 32'd30) begin n_err++; $display("FAIL held_lo: got %h expected 0000001e", bus.lo_out); end
    n_cmp++; if (bus.hi_out !== 32'd0) begin n_err++; $display("FAIL held_hi: got %h expected 00000000", bus.hi_out); end
    // The edge closing the FINISH cycle must not accept the held start
    @(posedge clock); #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL finish_start_ignored_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL finish_start_single_done: got %b expected 0", bus.done); end
    // Start still high in the following IDLE cycle is accepted
    run_op(OP_MULT, 32'd3, 32'd4, edges, busy_cnt, dz_cnt, got_done);
    n_cmp++; if (edges != 33) begin n_err++; $display("FAIL restart_latency: got %0d edges expected 33", edges); end
    n_cmp++; if (busy_cnt != 32) begin n_err++; $display("FAIL restart_busy: got %0d expected 32", busy_cnt); end
    n_cmp++; if (bus.lo_out !== 32'd12) begin n_err++; $display("FAIL restart_lo: got %h expected 0000000c", bus.lo_out); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_reset_mid_run();
    test_mult_corners();
    test_div();
    test_div_zero();
    test_start_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multicycle signed MULT/DIV datapath block. Sits directly downstream of the multicycle control unit, which issues a one-cycle start with operands from A/B and stalls in a wait state until done.
- Produces the HI/LO register pair, consumed by MFHI/MFLO through the mem_to_reg mux.
- Reports divide-by-zero to the control unit's exception path.

Parameters:
WIDTH, 32, operand width; also the iteration count; hi_out/lo_out are each WIDTH bits

Ports:
clock  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
start  in  1  begin an operation; sampled only in IDLE
op  in  1  0 = MULT, 1 = DIV
a_in  in  WIDTH  rs operand (multiplicand / dividend), signed
b_in  in  WIDTH  rt operand (multiplier / divisor), signed
busy  out  1  high while iterating (RUN state)
done  out  1  one-cycle pulse, result final
div_zero  out  1  one-cycle pulse with done when DIV with b_in==0
hi_out  out  WIDTH  HI register
lo_out  out  WIDTH  LO register

Behaviour:
- Reset (reset==0, async):
  - State goes to IDLE; counter = 0.
  - busy, done and div_zero = 0; hi_out and lo_out = 0.
  - An in-flight operation is aborted and no done is issued.
- States:
  - IDLE: start==1 at edge E0 latches op, a_in and b_in, then goes to RUN, or to FINISH if op==1 and b_in==0.
  - RUN: one iteration per edge, counter 0..WIDTH-1. At edge E32 (counter==WIDTH-1) the result is written to hi_out/lo_out and the state goes to FINISH.
  - FINISH: done=1 for exactly one cycle, then IDLE on the next edge.
- Latency:
  - Normal operation: done is high in the cycle after E32, i.e. 33 edges after the start edge. hi/lo are valid from E32 onward. busy is high in the cycles after E0 through E32.
  - Divide by zero: done and div_zero are high in the cycle after E0. hi/lo are unchanged.
- start outside IDLE is ignored: no restart and no queueing. Operands are captured at E0 only, so a_in/b_in may change afterwards.
- A start in the FINISH cycle is ignored. The control unit must reissue it once the unit is in IDLE.
- MULT:
  - Radix-2 Booth over a 2*WIDTH+1 product register.
  - Result is {hi_out, lo_out} = signed a × signed b, as a full 64-bit two's-complement product.
- DIV:
  - Restoring unsigned division on |a| and |b|; |MIN_INT| is taken as unsigned 0x80000000.
  - lo_out = quotient, truncated toward zero. Negated if sign(a) != sign(b).
  - hi_out = remainder, with the sign of the dividend.
  - Overflow case 0x80000000 / -1: lo_out = 0x80000000, hi_out = 0. No exception.
- hi_out/lo_out hold their value between operations. They change only at the final RUN edge or at reset.
- div_zero is never high without done.

Test Plan:
- Reset mid-RUN: start MULT 5×7, drive reset=0 at cycle 10 -> busy/done=0, hi/lo=0 immediately. No done pulse follows after reset is released.
- MULT 7 × -3 -> done 33 edges after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for exactly 32 cycles.
- MULT 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0x00000000. Also 0xFFFFFFFF × 0xFFFFFFFF -> hi=0, lo=1.
- DIV -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV 100 / 0 with prior hi=0x11, lo=0x22 -> done and div_zero high in the cycle after start; hi=0x11, lo=0x22 unchanged; busy never high.
- Start held high through an operation, with operands changed after E0 -> exactly one done, result from the E0 operands. A start in the FINISH cycle is ignored; a start one cycle later is accepted.
